// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the camera/Ethernet link mode sequencer.
package mode_seq_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned WD_W            = 32;
  localparam int unsigned CMD_IDLE        = 0;
  localparam int unsigned TIMEOUT_CYC_DEF = 50_000_000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_CMD_WAIT = 3'd2,
    ST_PIC      = 3'd3,
    ST_PIC_WAIT = 3'd4,
    ST_HOLD     = 3'd5,
    ST_RET_CMD  = 3'd6,
    ST_RET_WAIT = 3'd7
  } state_e;

  // States in which the watchdog is allowed to count.
  function automatic logic wd_runs(input state_e st);
    return (st == ST_CMD) || (st == ST_CMD_WAIT) || (st == ST_PIC_WAIT) ||
           (st == ST_RET_CMD) || (st == ST_RET_WAIT);
  endfunction

endpackage

// File: rtl/mode_seq_if.sv
// Command-sender and picture-engine handshake bundle of the mode sequencer.
interface mode_seq_if #(
  parameter int unsigned CMD_W = 2
) ();

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_code;
  logic             cmd_ready;
  logic             cmd_done;
  logic             pic_start;
  logic             pic_done;

  modport master (
    output cmd_valid, cmd_code, pic_start,
    input  cmd_ready, cmd_done, pic_done
  );

  modport slave (
    input  cmd_valid, cmd_code, pic_start,
    output cmd_ready, cmd_done, pic_done
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge_det (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [2:0] arm;

  // Pulses stay masked until prev holds a real sample, so a level held
  // high through reset is never mistaken for an edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      arm   <= 3'b000;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      prev  <= s2;
      arm   <= {arm[1:0], 1'b1};
      pulse <= arm[2] & s2 & ~prev;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Top-level mode controller: request arbitration, command handshake, picture launch.
// Optional watchdog enabled by defining MODE_SEQ_TIMEOUT_EN.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int unsigned          NUM_REQ     = 3,
  parameter int unsigned          CMD_W       = 2,
  parameter logic [NUM_REQ-1:0]   STREAM_MASK = NUM_REQ'(3'b100),
  parameter int unsigned          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               next_req,
  input  logic               finish_req,
  mode_seq_if.master         bus,
  output logic [CMD_W-1:0]   active_mode,
  output logic [STATE_W-1:0] state_o,
  output logic               err_timeout
);

  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("mode_sequencer: NUM_REQ must be at least 2");
  end
  if (CMD_W < $clog2(NUM_REQ + 1)) begin : g_chk_cmd_w
    $error("mode_sequencer: CMD_W too narrow for NUM_REQ");
  end

  logic [NUM_REQ-1:0] req_edge;
  logic               next_edge;
  logic               fin_edge;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_sync
    sync_edge_det u_req_sync (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .din     (req[g]),
      .pulse   (req_edge[g])
    );
  end

  sync_edge_det u_next_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .din     (next_req),
    .pulse   (next_edge)
  );

  sync_edge_det u_fin_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .din     (finish_req),
    .pulse   (fin_edge)
  );

  // Lowest-index request edge wins; the rest are dropped.
  logic             sel_hit;
  logic [CMD_W-1:0] sel_code;
  logic             sel_stream;

  always_comb begin
    sel_hit    = 1'b0;
    sel_code   = '0;
    sel_stream = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_edge[i]) begin
        sel_hit    = 1'b1;
        sel_code   = CMD_W'(i + 1);
        sel_stream = STREAM_MASK[i];
      end
    end
  end

  state_e           state;
  state_e           state_nxt;
  logic [CMD_W-1:0] mode_q;
  logic [CMD_W-1:0] mode_nxt;
  logic             stream_q;
  logic             stream_nxt;
  logic             pend_q;
  logic             pend_nxt;
  logic             wd_hit;
  logic             err_set;
  logic             err_clr;

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    stream_nxt = stream_q;
    pend_nxt   = pend_q;
    err_set    = 1'b0;
    err_clr    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (sel_hit) begin
          state_nxt  = ST_CMD;
          mode_nxt   = sel_code;
          stream_nxt = sel_stream;
          err_clr    = 1'b1;
        end
      end
      ST_CMD:      if (bus.cmd_ready) state_nxt = ST_CMD_WAIT;
      ST_CMD_WAIT: if (bus.cmd_done)  state_nxt = ST_PIC;
      ST_PIC:      state_nxt = ST_PIC_WAIT;
      ST_PIC_WAIT: begin
        // A finish seen while the picture is in flight ends streaming early.
        if (bus.pic_done) begin
          state_nxt = (stream_q && !(pend_q || fin_edge)) ? ST_HOLD : ST_RET_CMD;
        end else if (fin_edge && stream_q) begin
          pend_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (fin_edge)       state_nxt = ST_RET_CMD;
        else if (next_edge) state_nxt = ST_PIC;
      end
      ST_RET_CMD: begin
        pend_nxt = 1'b0;
        if (bus.cmd_ready) state_nxt = ST_RET_WAIT;
      end
      ST_RET_WAIT: if (bus.cmd_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase

    // Watchdog expiry only bites when no regular transition is taken.
    if (wd_hit && (state_nxt == state)) begin
      err_set   = 1'b1;
      state_nxt = ((state == ST_RET_CMD) || (state == ST_RET_WAIT)) ? ST_IDLE : ST_RET_CMD;
    end

    if (state_nxt == ST_IDLE) begin
      mode_nxt = '0;
      pend_nxt = 1'b0;
    end
  end

  // State, mode context and all handshake outputs registered from next state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mode_q        <= '0;
      stream_q      <= 1'b0;
      pend_q        <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_code  <= '0;
      bus.pic_start <= 1'b0;
    end else begin
      state         <= state_nxt;
      mode_q        <= mode_nxt;
      stream_q      <= stream_nxt;
      pend_q        <= pend_nxt;
      bus.cmd_valid <= (state_nxt == ST_CMD) || (state_nxt == ST_RET_CMD);
      bus.cmd_code  <= (state_nxt == ST_CMD) ? mode_nxt : CMD_W'(CMD_IDLE);
      bus.pic_start <= (state_nxt == ST_PIC);
    end
  end

  assign active_mode = mode_q;
  assign state_o     = state;

`ifdef MODE_SEQ_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_hit = wd_runs(state) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state_nxt != state) || !wd_runs(state)) wd_cnt <= '0;
      else                                          wd_cnt <= wd_cnt + WD_W'(1);
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_wd;

  assign wd_hit      = 1'b0;
  assign err_timeout = 1'b0;
  assign unused_wd   = err_set | err_clr | (TIMEOUT_CYC == 0);
`endif

endmodule
